uart_tx: RTL
============

# uart_tx

8N1 UART transmitter with a one-entry holding register. Serializes bytes from the command/control logic onto the `TX` line, LSB first, at a fixed clocks-per-bit rate. The holding register allows the next byte to be queued mid-frame so consecutive frames go out back-to-back with no idle gap. It is the transmit half of the design's serial link and pairs with the existing UART receiver, using the same baud constant.

## Interface
- `BAUD`, default 12'hA2C (2604): clocks per bit. Legal range is 2 to 4095.
- `clk` in, 1 bit: system clock. All logic is on the rising edge.
- `rst` in, 1 bit: synchronous, active-high reset. One clock; reset is synchronous and active-high.
- `trmt` in, 1 bit: transmit request. Accepted only in a cycle where `tx_rdy` is 1.
- `tx_data` in, 8 bits: byte to send. Sampled in the same cycle `trmt` is accepted.
- `TX` out, 1 bit: serial line, registered. Idles high.
- `tx_rdy` out, 1 bit: 1 when the holding register is empty and a `trmt` will be accepted.
- `busy` out, 1 bit: 1 while a frame is on the line.
- `tx_done` out, 1 bit: one-cycle pulse per completed frame.

## Operation
- **Frame format:** 10 bits, in order:
  - start bit (0)
  - `tx_data[0]` through `tx_data[7]`
  - stop bit (1)
  - Each bit is held for exactly `BAUD` clocks.
- **Datapath:**
  - 10-bit shift register, loaded with {1, data, 0}. Shifts right, shifting in 1; `TX` is the LSB.
  - Baud counter counts up from 0; a shift happens when it reaches `BAUD-1`, and the counter then wraps to 0.
  - 4-bit bit counter, 0 to 10.
  - 8-bit holding register plus a `hold_full` flag.
- **States:**
  - IDLE: `TX`=1, `busy`=0. An accepted `trmt` loads the shift register directly, bypassing the holding register, clears both counters and moves to TRANSMIT.
  - TRANSMIT: shifts on each baud tick. An accepted `trmt` loads the holding register and sets `hold_full`.
  - **Frame end** is the baud tick on which the bit counter goes to 10. At that edge:
    - `tx_done` pulses.
    - If `hold_full` is set, or `trmt` is accepted in that same cycle: load the shift register from that byte, clear `hold_full`, clear both counters and stay in TRANSMIT.
    - Otherwise: go to IDLE.
- `tx_rdy` = !`hold_full`. It is 1 in IDLE.
- `trmt` while `tx_rdy`=0 is ignored. The held byte is not overwritten.
- Reset values: `TX`=1, `busy`=0, `tx_rdy`=1, `tx_done`=0, state IDLE, `hold_full`=0, counters 0.
- Reset asserted mid-frame:
  - At the next edge `TX` returns to 1 and the queued byte is discarded.
  - No `tx_done` pulse is produced for the aborted frame.

## Timing
- `trmt` accepted in IDLE at edge E-1 (sampled): `TX`=0 and `busy`=1 from edge E.
- Bit k (start = 0, stop = 9) drives `TX` during [E + k·BAUD, E + (k+1)·BAUD).
- Frame end is at edge E + 10·BAUD. `tx_done`=1 for exactly the cycle following that edge.
  - Nothing queued: `busy` and `TX` go to 0 and 1 at that same edge.
  - Byte queued: the next start bit begins at that edge, so there is zero gap between frames.
- `tx_rdy` falls at the edge after a TRANSMIT-state accept and rises at the frame-end edge that consumes the held byte.
- Maximum throughput: one byte per 10·BAUD clocks.

## Structure
- Shared package `uart_pkg` holds:
  - `BAUD_DEFAULT` (12'hA2C), also used by the receiver
  - `FRAME_BITS` (10)
  - `tx_state_t` enum {IDLE, TRANSMIT}
- Sub-module `uart_baud_gen`: an up-counter with a clear input and a one-cycle `tick` output at `BAUD-1`. The receiver can reuse it later.
- The FSM, shift register and holding register stay in `uart_tx`.

## Test plan
- **Single byte:** reset, then `trmt` with 8'hA5 in IDLE, `BAUD`=16.
  - `TX` sampled mid-bit reads 0,1,0,1,0,0,1,0,1,1.
  - `tx_done` pulses once, 160 clocks after `TX` falls; `busy` falls at the same edge.
- **Back-to-back:** 8'h00 then 8'hFF queued mid-frame.
  - `tx_rdy` drops, then rises at the first frame end.
  - The second start bit immediately follows the first stop bit, with no high gap.
  - Two `tx_done` pulses, 160 clocks apart.
- **Overflow:** a third `trmt` (8'h3C) while `hold_full`. It is ignored; only 8'h00 and 8'hFF appear on `TX`.
- **Simultaneous event:** `trmt` with 8'h5A in the exact frame-end cycle with the holding register empty. The 8'h5A frame starts with zero gap, and `tx_done` still pulses for the prior frame.
- **Reset mid-frame:** `rst` at bit 4 with a byte queued.
  - `TX`=1, `busy`=0 and `tx_rdy`=1 at the next edge; no `tx_done`.
  - A following `trmt` with 8'h81 transmits cleanly.
- **Loopback:** connect `TX` to the receiver at default `BAUD`, send 8'h00, 8'h55, 8'hAA, 8'hFF. All four are received intact.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Package : uart_pkg
// Brief   : Shared constants and types for the UART transmitter and receiver
// Rev     : 1.0
// ============================================================================
package uart_pkg;

    localparam logic [11:0] BAUD_DEFAULT = 12'hA2C;
    localparam int          FRAME_BITS   = 10;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        TRANSMIT = 1'b1
    } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_tx_if.sv
`default_nettype none
// ============================================================================
// Interface : uart_tx_if
// Brief     : Byte handshake and serial line of the UART transmitter
// Rev       : 1.0
// ============================================================================
interface uart_tx_if;

    logic       trmt;
    logic [7:0] tx_data;
    logic       tx_rdy;
    logic       busy;
    logic       tx_done;
    logic       TX;

    modport master (
        output trmt,
        output tx_data,
        input  tx_rdy,
        input  busy,
        input  tx_done,
        input  TX
    );

    modport slave (
        input  trmt,
        input  tx_data,
        output tx_rdy,
        output busy,
        output tx_done,
        output TX
    );

endinterface
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ============================================================================
// Module : uart_baud_gen
// Brief  : Clearable up-counter producing a one-cycle tick every BAUD clocks
// Rev    : 1.0
// ============================================================================
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter logic [11:0] BAUD = BAUD_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam logic [11:0] c_LAST = BAUD - 12'd1;

    logic [11:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt <= 12'd0;
        end else if (r_cnt == c_LAST) begin
            r_cnt <= 12'd0;
        end else begin
            r_cnt <= r_cnt + 12'd1;
        end
    end

    assign tick = (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module : uart_tx
// Brief  : 8N1 UART transmitter, LSB first, one-entry holding register
// Rev    : 1.0
// ============================================================================
module uart_tx
    import uart_pkg::*;
#(
    parameter logic [11:0] BAUD = BAUD_DEFAULT
) (
    input  logic     clk,
    input  logic     rst,
    uart_tx_if.slave bus
);

    localparam logic [3:0] c_LAST_BIT = 4'(FRAME_BITS - 1);

    tx_state_t             r_state;
    logic [FRAME_BITS-1:0] r_shift;
    logic [3:0]            r_bit_cnt;
    logic [7:0]            r_hold;
    logic                  r_hold_full;
    logic                  r_tx_done;

    logic w_tick;
    logic w_accept;
    logic w_frame_end;
    logic w_baud_clr;

    assign w_accept    = bus.trmt && !r_hold_full;
    assign w_frame_end = (r_state == TRANSMIT) && w_tick && (r_bit_cnt == c_LAST_BIT);
    // Counter is held at zero while idle so the first bit is exactly BAUD clocks.
    assign w_baud_clr  = (r_state == IDLE) || w_frame_end;

    uart_baud_gen #(
        .BAUD (BAUD)
    ) u_baud_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_baud_clr),
        .tick (w_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_shift     <= '1;
            r_bit_cnt   <= 4'd0;
            r_hold      <= 8'd0;
            r_hold_full <= 1'b0;
            r_tx_done   <= 1'b0;
        end else begin
            r_tx_done <= w_frame_end;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_shift   <= {1'b1, bus.tx_data, 1'b0};
                        r_bit_cnt <= 4'd0;
                        r_state   <= TRANSMIT;
                    end
                end
                TRANSMIT: begin
                    if (w_frame_end) begin
                        r_bit_cnt <= 4'd0;
                        // Reload on the stop-bit edge itself so frames abut with no gap.
                        if (r_hold_full) begin
                            r_shift     <= {1'b1, r_hold, 1'b0};
                            r_hold_full <= 1'b0;
                        end else if (w_accept) begin
                            r_shift <= {1'b1, bus.tx_data, 1'b0};
                        end else begin
                            r_shift <= '1;
                            r_state <= IDLE;
                        end
                    end else begin
                        if (w_tick) begin
                            r_shift   <= {1'b1, r_shift[FRAME_BITS-1:1]};
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end
                        if (w_accept) begin
                            r_hold      <= bus.tx_data;
                            r_hold_full <= 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.TX      = r_shift[0];
    assign bus.busy    = (r_state == TRANSMIT);
    assign bus.tx_rdy  = !r_hold_full;
    assign bus.tx_done = r_tx_done;

endmodule
`default_nettype wire
